// File: rtl/psum_acc_pkg.sv
// psum_acc_pkg: shared types and helpers for the partial-sum accumulator.
//   state_t   - stage-2 FSM states
//   psum_size - width of one upstream partial sum
//   sat_add   - saturating signed add at a run-time-constant width,
//               returned as {sum, ovf}
package psum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  // Internal width used by sat_add. Callers sign-extend operands to WIDE bits,
  // so any accumulator width up to WIDE-1 can share one helper.
  localparam int WIDE = 64;

  function automatic int psum_size(input int in0, input int in1);
    return in0 + in1 + 8;
  endfunction

  // Adds a and b, saturating to the signed range of 'width' bits.
  // Result layout: [WIDE:1] = sum (sign-extended), [0] = overflow.
  function automatic logic [WIDE:0] sat_add(input logic signed [WIDE-1:0] a,
                                            input logic signed [WIDE-1:0] b,
                                            input int width);
    logic signed [WIDE:0]   full;
    logic signed [WIDE:0]   maxv;
    logic signed [WIDE:0]   minv;
    logic signed [WIDE-1:0] sum;
    logic                   ovf;
    full = (WIDE+1)'(a) + (WIDE+1)'(b);
    maxv = ({{WIDE{1'b0}}, 1'b1} << (width - 1)) - 1'b1;
    minv = ~maxv;
    ovf  = 1'b1;
    if (full > maxv) begin
      sum = maxv[WIDE-1:0];
    end else if (full < minv) begin
      sum = minv[WIDE-1:0];
    end else begin
      sum = full[WIDE-1:0];
      ovf = 1'b0;
    end
    return {sum, ovf};
  endfunction

endpackage

// File: rtl/psum_resolve.sv
// psum_resolve: stage-1 register slice. Resolves the redundant partial-sum
// pair into one signed value and tags it with "last beat of this result".
//   clk_i, rst_ni   - clock, async active-low reset
//   psum_i          - signed partial-sum pair from the dot-product core
//   psum_valid_i    - pair valid
//   psum_ready_o    - pair accepted when valid && ready
//   len_i           - beats per result, sampled on the first beat
//   s1_consume_i    - stage 2 takes the registered beat this cycle
//   s1_sum_o        - registered resolved sum (PSUM_SIZE+1 bits)
//   s1_valid_o      - registered beat present
//   s1_last_o       - registered beat closes its result
//   busy_o          - a result is in progress
module psum_resolve
  import psum_acc_pkg::*;
#(
  parameter int PSUM_SIZE = 20,
  parameter int LEN_WIDTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [1:0][PSUM_SIZE-1:0]   psum_i,
  input  logic                        psum_valid_i,
  output logic                        psum_ready_o,
  input  logic [LEN_WIDTH-1:0]        len_i,
  input  logic                        s1_consume_i,
  output logic signed [PSUM_SIZE:0]   s1_sum_o,
  output logic                        s1_valid_o,
  output logic                        s1_last_o,
  output logic                        busy_o
);

  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 accept;

  // Ready depends only on registered state and the downstream consume,
  // never on psum_valid_i.
  assign psum_ready_o = !s1_valid_o || s1_consume_i;
  assign accept       = psum_valid_i && psum_ready_o;
  assign busy_o       = (beat_cnt != '0) || s1_valid_o;

  // Beats still to come after the one being accepted; len_i=0 acts as 1.
  always_comb begin
    remaining = '0;
    if (beat_cnt == '0) begin
      if (len_i != '0) remaining = len_i - 1'b1;
    end else begin
      remaining = beat_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt   <= '0;
      s1_sum_o   <= '0;
      s1_valid_o <= 1'b0;
      s1_last_o  <= 1'b0;
    end else if (accept) begin
      beat_cnt   <= remaining;
      s1_sum_o   <= (PSUM_SIZE+1)'(signed'(psum_i[0]))
                  + (PSUM_SIZE+1)'(signed'(psum_i[1]));
      s1_valid_o <= 1'b1;
      s1_last_o  <= (remaining == '0);
    end else if (s1_consume_i) begin
      s1_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: resolves partial-sum pairs from the dot-product core and
// accumulates len_i beats into one saturating signed result.
//   clk_i, rst_ni  - clock, async active-low reset
//   psum_i         - signed partial-sum pair (packed [1:0][PSUM_SIZE-1:0])
//   psum_valid_i   - pair valid
//   psum_ready_o   - pair accepted when valid && ready
//   len_i          - beats per result, sampled on the first beat
//   acc_o          - signed accumulated result
//   acc_valid_o    - result valid
//   acc_ready_i    - result consumed when valid && ready
//   acc_sat_o      - result saturated (qualified by acc_valid_o)
//   busy_o         - a result is in progress
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int IN_SIZE_0 = 4,
  parameter int IN_SIZE_1 = 8,
  parameter int ACC_SIZE  = 32,
  parameter int LEN_WIDTH = 8,
  localparam int PSUM_SIZE = psum_size(IN_SIZE_0, IN_SIZE_1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [1:0][PSUM_SIZE-1:0]   psum_i,
  input  logic                        psum_valid_i,
  output logic                        psum_ready_o,
  input  logic [LEN_WIDTH-1:0]        len_i,
  output logic [ACC_SIZE-1:0]         acc_o,
  output logic                        acc_valid_o,
  input  logic                        acc_ready_i,
  output logic                        acc_sat_o,
  output logic                        busy_o
);

  state_t                      state;
  logic signed [ACC_SIZE-1:0]  acc_q;
  logic                        sat_q;
  logic                        acc_valid_q;

  logic signed [PSUM_SIZE:0]   s1_sum;
  logic                        s1_valid;
  logic                        s1_last;
  logic                        s1_consume;

  logic [WIDE:0]               sa;
  logic signed [ACC_SIZE-1:0]  acc_next;
  logic                        acc_ovf;
  logic                        unused_sa_hi;

  assign s1_consume = s1_valid && (state != HOLD || acc_ready_i);

  psum_resolve #(
    .PSUM_SIZE (PSUM_SIZE),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_resolve (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .psum_i       (psum_i),
    .psum_valid_i (psum_valid_i),
    .psum_ready_o (psum_ready_o),
    .len_i        (len_i),
    .s1_consume_i (s1_consume),
    .s1_sum_o     (s1_sum),
    .s1_valid_o   (s1_valid),
    .s1_last_o    (s1_last),
    .busy_o       (busy_o)
  );

  always_comb begin
    sa = sat_add(WIDE'(acc_q), WIDE'(s1_sum), ACC_SIZE);
  end
  assign acc_next     = signed'(sa[ACC_SIZE:1]);
  assign acc_ovf      = sa[0];
  assign unused_sa_hi = ^sa[WIDE:ACC_SIZE+1];

  // The first beat of a result is loaded in IDLE, or straight out of HOLD
  // on the output handshake so back-to-back results need no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s1_valid) begin
            acc_q       <= ACC_SIZE'(s1_sum);
            sat_q       <= 1'b0;
            state       <= s1_last ? HOLD : ACCUM;
            acc_valid_q <= s1_last;
          end
        end
        ACCUM: begin
          if (s1_valid) begin
            // Once saturated the value is frozen; beats are still counted.
            if (!sat_q) acc_q <= acc_next;
            sat_q       <= sat_q | acc_ovf;
            state       <= s1_last ? HOLD : ACCUM;
            acc_valid_q <= s1_last;
          end
        end
        HOLD: begin
          if (acc_ready_i) begin
            if (s1_valid) begin
              acc_q       <= ACC_SIZE'(s1_sum);
              sat_q       <= 1'b0;
              state       <= s1_last ? HOLD : ACCUM;
              acc_valid_q <= s1_last;
            end else begin
              state       <= IDLE;
              acc_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          acc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign acc_o       = acc_q;
  assign acc_sat_o   = sat_q;
  assign acc_valid_o = acc_valid_q;

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream neighbour of the `baseline` dot-product core.
- The core emits each 8-lane dot product as a redundant pair of signed partial sums, out[0] and out[1]; the true value is their sum.
- This block resolves the pair, then accumulates NUM beats (chunks of a longer vector) into one wide signed result.
- The result is presented on a valid/ready output with backpressure toward the core.

Parameters:
- IN_SIZE_0, 4, operand-0 width of the upstream core.
- IN_SIZE_1, 8, operand-1 width of the upstream core.
- ACC_SIZE, 32, accumulator/result width; must be >= PSUM_SIZE+1.
- LEN_WIDTH, 8, width of the chunk-count field.
- Derived, not overridable: PSUM_SIZE = IN_SIZE_0+IN_SIZE_1+8 (20 with defaults).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- psum_i  in  2xPSUM_SIZE (packed [1:0][PSUM_SIZE-1:0])  signed partial-sum pair.
- psum_valid_i  in  1  pair valid.
- psum_ready_o  out  1  pair accepted when valid&&ready.
- len_i  in  LEN_WIDTH  beats per result; sampled on the first beat of each result.
- acc_o  out  ACC_SIZE  signed accumulated result.
- acc_valid_o  out  1  result valid.
- acc_ready_i  in  1  result consumed when valid&&ready.
- acc_sat_o  out  1  result saturated; qualified by acc_valid_o.
- busy_o  out  1  a result is in progress (beat counter != 0 or stage-1 full).

Reset is asynchronous, active-low (rst_ni); all flops clear immediately on assertion. One clock, clk_i.

Behaviour:
- Reset values:
  - acc_o=0, acc_valid_o=0, acc_sat_o=0, busy_o=0.
  - psum_ready_o=1, since it is derived from the empty stage 1.
  - Internal beat counter=0, FSM=IDLE.
- Stage 1 (resolve):
  - On accept, register s1_sum = sext(psum_i[0]) + sext(psum_i[1]) at PSUM_SIZE+1 bits.
  - Register s1_last from the input beat counter.
  - Register s1_valid.
- Input beat counter:
  - At 0, an accepted beat latches remaining = max(len_i,1)-1; len_i=0 is treated as 1.
  - Each further accept decrements it.
  - s1_last=1 when the count after this beat is 0.
- psum_ready_o = !s1_valid || s1_consume (combinational from registers and acc_ready_i). No combinational path from psum_valid_i.
- Stage 2 FSM:
  - IDLE: s1_valid -> load acc = sext(s1_sum), clear sat; go to HOLD if s1_last, else ACCUM.
  - ACCUM: s1_valid -> acc = sat(acc + s1_sum); go to HOLD if s1_last.
  - HOLD: acc_valid_o=1; acc_o, acc_sat_o stable. On acc_ready_i:
    - if s1_valid, load the new first beat exactly as in IDLE (zero-bubble);
    - else go to IDLE.
- s1_consume = s1_valid && (state!=HOLD || acc_ready_i).
- Arithmetic and saturation:
  - Two's complement throughout.
  - On overflow, saturate to +2^(ACC_SIZE-1)-1 or -2^(ACC_SIZE-1).
  - Set a sticky sat flag for the rest of that result.
  - Once saturated, the value is held; further beats still count.
- Latency: a pair accepted in cycle N with len=1 gives acc_valid_o in N+2.
- Throughput: one pair/cycle sustained while acc_ready_i=1, including back-to-back len=1 results.
- Backpressure: with acc_ready_i=0 in HOLD, stage 1 absorbs exactly one beat, then psum_ready_o=0 until the output handshake.
- Reset mid-result: all partial state is discarded; the first beat after release starts a new result with a fresh len_i.
- Simultaneous output handshake and input accept in HOLD are both honoured in the same cycle.

Decomposition:
- psum_acc_pkg holds:
  - state enum (IDLE, ACCUM, HOLD);
  - function psum_size(in0,in1) returning in0+in1+8;
  - function sat_add(a,b) returning {sum,ovf} at ACC_SIZE.
- One sub-module: psum_resolve, the stage-1 register slice (pair add plus valid/last with ready).

Test Plan:
- len=1, psum={20'sd100, -20'sd30}, acc_ready_i=1 -> acc_o=70, acc_valid_o exactly 2 cycles after accept, acc_sat_o=0.
- len=4, pairs summing 1, -2, 3, 4 -> acc_o=6 after the 4th beat; len_i changed to 9 mid-result is ignored.
- Back-to-back len=1 pairs summing 5, 6, 7, psum_valid_i held high -> acc_o 5, 6, 7 on consecutive cycles, psum_ready_o never low.
- Backpressure: acc_ready_i=0 for 5 cycles in HOLD -> acc_o held, one extra beat accepted, then psum_ready_o=0; it returns to 1 in the handshake cycle.
- Saturation (ACC_SIZE=21), len=4, each pair {2^19-1, 2^19-1} -> acc_o=2^20-1, acc_sat_o=1; next len=1 result 3 -> acc_sat_o=0.
- rst_ni low after 2 of 4 beats, and len=0 after release with a pair summing -8 -> no stale output; acc_o=-8 after one beat.
